video_bus_host: RTL and testbench
=================================

// Module: video_bus_host
// PURPOSE
//  Initiator for the video controller's host bus (sel_ram/sel_ctl/we/addr/din, ram_dout/ctl_dout).
//  Decodes a byte-wide command stream (e.g. from a UART or SPI front end) into VRAM and
//  control-register writes, fills and reads. Read data returns on a byte response stream.
//  Sits between the command transport and the video instance, in the clk domain.
// PARAMETERS
//  ADDR_W      13  video bus address width; pointer wraps modulo 2**ADDR_W
//  RD_LATENCY  1   cycles from a read strobe to valid ram_din/ctl_din (1..3)
// PORTS
//  clk        in   1       system clock (post-PLL, global buffer)
//  NRST       in   1       asynchronous active-low reset
//  cmd_data   in   8       command/argument/data byte
//  cmd_valid  in   1       cmd_data valid
//  cmd_ready  out  1       byte accepted when cmd_valid & cmd_ready
//  rsp_data   out  8       read-back byte
//  rsp_valid  out  1       rsp_data valid; held until rsp_ready
//  rsp_ready  in   1       consumer accepts rsp_data
//  sel_ram    out  1       VRAM select strobe
//  sel_ctl    out  1       control-register select strobe
//  we         out  1       write enable (qualifies sel_*)
//  addr       out  ADDR_W  bus address
//  dout       out  8       write data (to video din)
//  ram_din    in   8       VRAM read data (from video ram_dout)
//  ctl_din    in   8       control read data (from video ctl_dout)
//  busy       out  1       high whenever FSM is not in IDLE
//  err        out  1       one-cycle pulse on an unknown opcode
// BEHAVIOUR
//  Reset (NRST low, async): all outputs 0, addr pointer 0, FSM=IDLE; cmd_ready rises on the first clk after release.
//  Opcodes (first byte in IDLE); n=0 means 256; ptr = internal ADDR_W-bit address pointer:
//   0x10 SETADDR hi lo : ptr <= {hi,lo}[ADDR_W-1:0]; no bus cycle.
//   0x20 WRRAM n d0..dn-1 : each di -> VRAM write at ptr, ptr++.
//   0x30 WRCTL r v : ctl write, addr={0,r}; ptr unchanged.
//   0x40 RDRAM n : n VRAM reads at ptr, ptr++ each; each byte pushed to rsp.
//   0x50 FILL n v : n VRAM writes of v at ptr, ptr++; no further cmd bytes consumed.
//   0x60 RDCTL r : one ctl read at {0,r}; one rsp byte.
//   other : err pulses 1 cycle, byte discarded, stay IDLE.
//  States: IDLE, ARG1, ARG2, WDATA, FILL, RD_ISSUE, RD_WAIT, RD_RSP.
//  Bus write: sel_x=1, we=1, addr, dout registered, valid exactly one cycle; cycle N+1 after the
//   accepting handshake (WRRAM/WRCTL) or every cycle in FILL. WRRAM sustains 1 byte/cycle.
//  Bus read: sel_x=1, we=0 for one cycle at cycle R; data sampled at R+RD_LATENCY; rsp_valid
//   set next cycle, held with rsp_data stable until rsp_ready; next read issued the cycle after
//   the rsp handshake. At most one read outstanding.
//  sel_ram and sel_ctl never high together; all strobes 0 outside bus cycles; addr/dout may hold.
//  cmd_ready=1 only in IDLE, ARG1, ARG2, WDATA; 0 in FILL and all read states.
//  ptr wraps 2**ADDR_W-1 -> 0 without error. Count is 8-bit down-counter; state exits after last op.
//  NRST mid-command aborts immediately: strobes drop async, partial command lost, rsp_valid cleared.
// TESTING
//  1. Reset: NRST low with cmd_valid=1 -> all outputs 0; cmd_ready=1 one clk after release.
//  2. 10 01 00, 20 03 AA BB CC streamed back-to-back -> VRAM writes 0x100=AA,0x101=BB,0x102=CC on consecutive cycles.
//  3. 10 1F FF, 50 02 55 -> writes 0x1FFF=55 then 0x0000=55 (wrap); cmd_ready low for 2 cycles.
//  4. After 2, send 10 01 00, 40 03 with rsp_ready toggled 1/0 -> rsp 3 bytes matching ram_din model; no read strobe while rsp_valid & !rsp_ready.
//  5. 30 05 80 then 60 05 -> sel_ctl&we at addr 0x005, dout 0x80; then ctl read, rsp byte = ctl_din.
//  6. Byte 0x77 in IDLE -> err pulse 1 cycle, no strobes; NRST low mid-FILL n=0 -> strobes drop, FSM IDLE.

Source files
------------

// File: rtl/video_bus_host.sv
// rtl/video_bus_host.sv - byte command stream decoder driving the video controller host bus
module video_bus_host #(
  parameter int ADDR_W     = 13,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              NRST,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              sel_ram,
  output logic              sel_ctl,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        dout,
  input  logic [7:0]        ram_din,
  input  logic [7:0]        ctl_din,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] OP_SETADDR = 8'h10;
  localparam logic [7:0] OP_WRRAM   = 8'h20;
  localparam logic [7:0] OP_WRCTL   = 8'h30;
  localparam logic [7:0] OP_RDRAM   = 8'h40;
  localparam logic [7:0] OP_FILL    = 8'h50;
  localparam logic [7:0] OP_RDCTL   = 8'h60;
  localparam logic [1:0] LAT        = 2'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_ARG1, S_ARG2, S_WDATA, S_FILL, S_RD_ISSUE, S_RD_WAIT, S_RD_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d, arg_q, arg_d, val_q, val_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d, dout_q, dout_d;
  logic              sel_ram_q, sel_ram_d, sel_ctl_q, sel_ctl_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d, err_q, err_d;
  logic              cmd_fire, rsp_fire, issue_rd;

  // Next-state and next-output decode; strobes default low so every bus cycle lasts one clock
  always_comb begin
    cmd_fire    = cmd_valid & cmd_ready_q;
    rsp_fire    = rsp_valid_q & rsp_ready;
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    sel_ram_d   = 1'b0;
    sel_ctl_d   = 1'b0;
    we_d        = 1'b0;
    err_d       = 1'b0;
    issue_rd    = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_fire) begin
        op_d = cmd_data;
        case (cmd_data)
          OP_SETADDR, OP_WRRAM, OP_WRCTL, OP_RDRAM, OP_FILL, OP_RDCTL: state_d = S_ARG1;
          default: err_d = 1'b1;
        endcase
      end
      S_ARG1: if (cmd_fire) begin
        arg_d = cmd_data;
        case (op_q)
          OP_WRRAM: begin cnt_d = cmd_data; state_d = S_WDATA; end
          OP_RDRAM: begin cnt_d = cmd_data; state_d = S_RD_ISSUE; end
          OP_RDCTL: begin cnt_d = 8'd1; state_d = S_RD_ISSUE; end
          OP_FILL:  begin cnt_d = cmd_data; state_d = S_ARG2; end
          OP_SETADDR, OP_WRCTL: state_d = S_ARG2;
          default: state_d = S_IDLE;
        endcase
      end
      S_ARG2: if (cmd_fire) begin
        state_d = S_IDLE;
        case (op_q)
          OP_SETADDR: ptr_d = ADDR_W'({arg_q, cmd_data});
          OP_WRCTL: begin
            sel_ctl_d = 1'b1;
            we_d      = 1'b1;
            addr_d    = ADDR_W'(arg_q);
            dout_d    = cmd_data;
          end
          OP_FILL: begin val_d = cmd_data; state_d = S_FILL; end
          default: state_d = S_IDLE;
        endcase
      end
      S_WDATA: if (cmd_fire) begin
        sel_ram_d = 1'b1;
        we_d      = 1'b1;
        addr_d    = ptr_q;
        dout_d    = cmd_data;
        ptr_d     = ptr_q + 1'b1;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_IDLE;
      end
      S_FILL: begin
        sel_ram_d = 1'b1;
        we_d      = 1'b1;
        addr_d    = ptr_q;
        dout_d    = val_q;
        ptr_d     = ptr_q + 1'b1;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        issue_rd = 1'b1;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wcnt_q == LAT) begin
          rsp_data_d  = (op_q == OP_RDCTL) ? ctl_din : ram_din;
          rsp_valid_d = 1'b1;
          state_d     = S_RD_RSP;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_RD_RSP: if (rsp_fire) begin
        rsp_valid_d = 1'b0;
        if (cnt_q != 8'd0) begin
          issue_rd = 1'b1;
          state_d  = S_RD_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A read counts down on issue, so a zero count after a response means the command is done
    if (issue_rd) begin
      wcnt_d = 2'd0;
      cnt_d  = cnt_q - 8'd1;
      if (op_q == OP_RDCTL) begin
        sel_ctl_d = 1'b1;
        addr_d    = ADDR_W'(arg_q);
      end else begin
        sel_ram_d = 1'b1;
        addr_d    = ptr_q;
        ptr_d     = ptr_q + 1'b1;
      end
    end
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ARG1) ||
                  (state_d == S_ARG2) || (state_d == S_WDATA);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything so an in-flight command is abandoned
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q     <= S_IDLE;
      op_q        <= 8'd0;
      arg_q       <= 8'd0;
      val_q       <= 8'd0;
      cnt_q       <= 8'd0;
      ptr_q       <= '0;
      wcnt_q      <= 2'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      sel_ram_q   <= 1'b0;
      sel_ctl_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= 8'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sel_ram_q   <= sel_ram_d;
      sel_ctl_q   <= sel_ctl_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sel_ram   = sel_ram_q;
  assign sel_ctl   = sel_ctl_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_video_bus_host.sv
// tb/tb_video_bus_host.sv - randomized scoreboard bench for video_bus_host
module tb_video_bus_host;
  localparam int AW     = 13;
  localparam int TB_LAT = 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit            ctl;
    bit            wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            trig;
    bit            first;
  } op_t;

  logic          clk, NRST;
  logic [7:0]    cmd_data, rsp_data, dout, ram_din, ctl_din;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic          sel_ram, sel_ctl, we, busy, err;
  logic [AW-1:0] addr;

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] dev_mem [0:(1<<AW)-1];
  logic [7:0] exp_mem [0:(1<<AW)-1];
  logic [7:0] dev_ctl [0:255];
  logic [7:0] exp_ctl [0:255];
  op_t        exp_ops[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] rsp_log[$];
  int         hs_cyc[$];
  int byte_idx = 0, mptr = 0, exp_err = 0, err_seen = 0, rdy_low = 0, rdy_mode = 2;
  int last_rd_cyc = 0, last_rsp_hs = 0;
  bit gaps = 0;

  video_bus_host #(.ADDR_W(AW), .RD_LATENCY(TB_LAT)) dut (
    .clk(clk), .NRST(NRST), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .sel_ram(sel_ram), .sel_ctl(sel_ctl), .we(we), .addr(addr), .dout(dout),
    .ram_din(ram_din), .ctl_din(ctl_din), .busy(busy), .err(err)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog expired"); $fatal(1, "watchdog"); end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Command semantics: the list of bus cycles and response bytes a command must produce
  function automatic void model_cmd(input bq_t q, input int base);
    int n;
    n = (q.size() > 1) ? ((q[1] == 8'd0) ? 256 : int'(q[1])) : 0;
    case (q[0])
      8'h10: mptr = int'({q[1], q[2]}) % (1 << AW);
      8'h20: for (int i = 0; i < n; i++) begin
        exp_ops.push_back('{1'b0, 1'b1, AW'(mptr), q[2+i], base + 2 + i, 1'b0});
        exp_mem[mptr] = q[2+i];
        mptr = (mptr + 1) % (1 << AW);
      end
      8'h30: begin
        exp_ops.push_back('{1'b1, 1'b1, AW'(q[1]), q[2], base + 2, 1'b0});
        exp_ctl[q[1]] = q[2];
      end
      8'h40: for (int i = 0; i < n; i++) begin
        exp_ops.push_back('{1'b0, 1'b0, AW'(mptr), 8'h00, -1, i == 0});
        exp_rsp.push_back(exp_mem[mptr]);
        mptr = (mptr + 1) % (1 << AW);
      end
      8'h50: for (int i = 0; i < n; i++) begin
        exp_ops.push_back('{1'b0, 1'b1, AW'(mptr), q[2], -1, 1'b0});
        exp_mem[mptr] = q[2];
        mptr = (mptr + 1) % (1 << AW);
      end
      8'h60: begin
        exp_ops.push_back('{1'b1, 1'b0, AW'(q[1]), 8'h00, -1, 1'b1});
        exp_rsp.push_back(exp_ctl[q[1]]);
      end
      default: exp_err++;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin cmd_valid = 1'b0; @(posedge clk); #1; end
    cmd_data = b;
    cmd_valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; hs_cyc.push_back(cyc); end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    byte_idx++;
    if (!ok) begin
      hs_cyc.push_back(-100);
      checks++; failures++;
      $display("FAIL cmd_accept byte=0x%0h not accepted within bound", b);
    end
  endtask

  task automatic send_cmd(input bq_t q);
    model_cmd(q, byte_idx);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_ops.size() != 0 || exp_rsp.size() != 0 || busy) && t < 6000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (t >= 6000) begin
      failures++;
      $display("FAIL drain_timeout pending_ops=%0d pending_rsp=%0d required 0", exp_ops.size(), exp_rsp.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Video-side responder: applies writes and returns read data exactly RD_LATENCY cycles after the strobe
  initial begin
    int pend = 0; bit pctl = 0; logic [7:0] pv = 8'h00;
    ram_din = 8'h00; ctl_din = 8'h00;
    forever begin
      @(posedge clk); #1;
      ram_din = 8'($urandom); ctl_din = 8'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin if (pctl) ctl_din = pv; else ram_din = pv; end
      end
      if (!NRST) pend = 0;
      else if (sel_ram || sel_ctl) begin
        if (we) begin
          if (sel_ram) dev_mem[addr] = dout; else dev_ctl[addr[7:0]] = dout;
        end else begin
          pend = TB_LAT; pctl = sel_ctl;
          pv = sel_ram ? dev_mem[addr] : dev_ctl[addr[7:0]];
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'($urandom_range(0, 1));
        1:       rsp_ready = ~rsp_ready;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every bus cycle and response byte against the scoreboard
  initial begin
    op_t o; bit prev_rv = 0, prev_hold = 0, prev_err = 0; logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk);
      if (NRST) begin
        if (sel_ram || sel_ctl) begin
          chk("sel_exclusive", 32'(sel_ram & sel_ctl), 0);
          chk("strobe_while_rsp_valid", 32'(rsp_valid), 0);
          chk("strobe_expected", 32'(exp_ops.size() != 0), 1);
          if (exp_ops.size() != 0) begin
            o = exp_ops.pop_front();
            chk("bus_kind", 32'({sel_ctl, we}), 32'({o.ctl, o.wr}));
            chk("bus_addr", 32'(addr), 32'(o.a));
            if (o.wr) chk("bus_dout", 32'(dout), 32'(o.d));
            if (o.trig >= 0) chk("wr_latency", cyc - hs_cyc[o.trig], 1);
            if (!o.wr) begin
              if (!o.first) chk("rd_after_hs", cyc - last_rsp_hs, 1);
              last_rd_cyc = cyc;
            end
          end
        end else if (we) chk("we_qualified", 32'(we), 0);
        if (rsp_valid && !prev_rv) chk("rsp_latency", cyc - last_rd_cyc, TB_LAT + 1);
        if (prev_hold) begin
          chk("rsp_valid_hold", 32'(rsp_valid), 1);
          chk("rsp_data_hold", 32'(rsp_data), 32'(held));
        end
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
          if (exp_rsp.size() != 0) chk("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
          rsp_log.push_back(rsp_data);
          last_rsp_hs = cyc;
        end
        if (err) begin err_seen++; chk("err_single", 32'(prev_err), 0); end
        if (!cmd_ready) rdy_low++;
        prev_hold = rsp_valid && !rsp_ready;
        held = rsp_data;
        prev_rv = rsp_valid;
        prev_err = err;
      end else begin
        prev_rv = 0; prev_hold = 0; prev_err = 0;
      end
    end
  end

  initial begin
    bq_t q; int base, e0, n; logic [7:0] b;
    for (int i = 0; i < (1 << AW); i++) begin dev_mem[i] = 8'(i * 37 + 11); exp_mem[i] = 8'(i * 37 + 11); end
    for (int i = 0; i < 256; i++) begin dev_ctl[i] = 8'(i * 13 + 5); exp_ctl[i] = 8'(i * 13 + 5); end
    NRST = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h10;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 32'({cmd_ready, rsp_valid, sel_ram, sel_ctl, we, busy, err}), 0);
    chk("reset_data", 32'({rsp_data, addr, dout}), 0);
    NRST = 1'b1; cmd_valid = 1'b0;
    #1 chk("ready_before_clk", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_clk", 32'(cmd_ready), 1);
    @(posedge clk); #1;

    send_cmd('{8'h10, 8'h01, 8'h00});
    base = byte_idx;
    send_cmd('{8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC});
    drain();
    chk("wrram_b2b", hs_cyc[base+4] - hs_cyc[base+2], 2);
    chk("vram_100", 32'(dev_mem[13'h100]), 32'h AA);
    chk("vram_101", 32'(dev_mem[13'h101]), 32'h BB);
    chk("vram_102", 32'(dev_mem[13'h102]), 32'h CC);

    rdy_low = 0;
    send_cmd('{8'h10, 8'h1F, 8'hFF});
    send_cmd('{8'h50, 8'h02, 8'h55});
    drain();
    chk("fill_ready_low", rdy_low, 2);
    chk("vram_1fff", 32'(dev_mem[13'h1FFF]), 32'h55);
    chk("vram_0000", 32'(dev_mem[13'h0000]), 32'h55);

    rdy_mode = 1; rsp_log.delete();
    send_cmd('{8'h10, 8'h01, 8'h00});
    send_cmd('{8'h40, 8'h03});
    drain();
    chk("rd_count", rsp_log.size(), 3);
    chk("rd_byte0", 32'(rsp_log[0]), 32'h AA);
    chk("rd_byte1", 32'(rsp_log[1]), 32'h BB);
    chk("rd_byte2", 32'(rsp_log[2]), 32'h CC);

    rdy_mode = 2; rsp_log.delete();
    send_cmd('{8'h30, 8'h05, 8'h80});
    send_cmd('{8'h60, 8'h05});
    drain();
    chk("ctl_reg5", 32'(dev_ctl[5]), 32'h80);
    chk("ctl_rd", 32'(rsp_log[0]), 32'h80);

    rdy_mode = 0; gaps = 1;
    repeat (40) begin
      n = $urandom_range(1, 6);
      q.delete();
      case ($urandom_range(0, 6))
        0: q = '{8'h10, 8'($urandom), 8'($urandom)};
        1: begin q = '{8'h20, 8'(n)}; repeat (n) q.push_back(8'($urandom)); end
        2: q = '{8'h30, 8'($urandom), 8'($urandom)};
        3: q = '{8'h40, 8'(n)};
        4: q = '{8'h50, 8'(n), 8'($urandom)};
        5: q = '{8'h60, 8'($urandom)};
        default: begin
          b = 8'($urandom);
          if (b inside {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}) b = 8'h77;
          q = '{b};
        end
      endcase
      send_cmd(q);
    end
    drain();

    gaps = 0; rdy_mode = 2; e0 = err_seen;
    send_cmd('{8'h77});
    drain();
    chk("err_pulse_count", err_seen - e0, 1);
    chk("err_total", err_seen, exp_err);

    send_cmd('{8'h50, 8'h00, 8'h5A});
    repeat (20) @(negedge clk);
    chk("fill_active", 32'({busy, sel_ram, cmd_ready}), 32'b110);
    @(posedge clk); #2;
    NRST = 1'b0;
    #1 chk("abort_strobes", 32'({sel_ram, sel_ctl, we, busy, rsp_valid, cmd_ready}), 0);
    exp_ops.delete(); exp_rsp.delete(); mptr = 0;
    repeat (2) @(negedge clk);
    NRST = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'({busy, cmd_ready}), 32'b01);
    @(posedge clk); #1;
    rsp_log.delete();
    send_cmd('{8'h30, 8'h07, 8'h3C});
    send_cmd('{8'h60, 8'h07});
    drain();
    chk("post_abort_ctl", 32'(dev_ctl[7]), 32'h3C);
    chk("post_abort_rd", 32'(rsp_log[0]), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
